// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: debounced pedestrian key to pending-request level for the traffic-light controller
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic [1:0] light_state,
  input  logic       req_ack,
  output logic       ped_req,
  output logic       btn_level,
  output logic       wait_led,
  output logic [3:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES);
  typedef enum logic [1:0] {IDLE, PENDING, SERVED} state_t;
  state_t state, state_nx;
  logic btn_meta, btn_sync, btn_level_q, press, green;
  logic [DW-1:0] db_cnt;
  logic [BW-1:0] blink_cnt;
  assign press = btn_level & ~btn_level_q;
  assign green = light_state == 2'b00;
  // two-flop synchroniser on the inverted, active-low key
  always_ff @(posedge clk or posedge reset)
    if (reset) {btn_sync, btn_meta} <= '0;
    else {btn_sync, btn_meta} <= {btn_meta, ~btn_n};
  // level follows the synchronised key only after an unbroken run of mismatching cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      db_cnt <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) db_cnt <= '0;
    else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      btn_level <= btn_sync;
    end else db_cnt <= db_cnt + 1'b1;
  // previous debounced level, used to detect the rising edge of a press
  always_ff @(posedge clk or posedge reset)
    if (reset) btn_level_q <= 1'b0;
    else btn_level_q <= btn_level;
  // request state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // ack outranks a light change, which outranks a press
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (press && green) state_nx = PENDING;
      PENDING: state_nx = req_ack ? SERVED : (green ? PENDING : IDLE);
      SERVED: if (green) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // registered request level and saturating count of accepted requests
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ped_req <= 1'b0;
      press_count <= '0;
    end else begin
      ped_req <= state_nx == PENDING;
      if (state == IDLE && state_nx == PENDING && press_count != 4'hf) press_count <= press_count + 1'b1;
    end
  // wait indicator lights on entry to PENDING, then toggles every BLINK_CYCLES
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      blink_cnt <= '0;
      wait_led <= 1'b0;
    end else if (state_nx != PENDING) begin
      blink_cnt <= '0;
      wait_led <= 1'b0;
    end else if (state != PENDING) begin
      blink_cnt <= '0;
      wait_led <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      wait_led <= ~wait_led;
    end else blink_cnt <= blink_cnt + 1'b1;
endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb_ped_request_ctrl: directed self-checking bench for ped_request_ctrl
module tb_ped_request_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b1;
  logic [1:0] light_state = 2'b00;
  logic req_ack = 1'b0;
  logic ped_req, btn_level, wait_led;
  logic [3:0] press_count;
  int checks = 0;
  int errors = 0;
  ped_request_ctrl #(.DEBOUNCE_CYCLES(8), .BLINK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .light_state(light_state), .req_ack(req_ack),
    .ped_req(ped_req), .btn_level(btn_level), .wait_led(wait_led), .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step(3);
    #3 reset = 1'b1;
    #1;
    chk("rst_ped_req", {3'b0, ped_req}, 4'd0);
    chk("rst_btn_level", {3'b0, btn_level}, 4'd0);
    chk("rst_wait_led", {3'b0, wait_led}, 4'd0);
    chk("rst_count", press_count, 4'd0);
    step(2);
    reset = 1'b0;
    btn_n = 1'b0;
    step(9);
    chk("clean_level_e8", {3'b0, btn_level}, 4'd0);
    step(1);
    chk("clean_level_e9", {3'b0, btn_level}, 4'd1);
    chk("clean_req_e9", {3'b0, ped_req}, 4'd0);
    step(1);
    chk("clean_req_e10", {3'b0, ped_req}, 4'd1);
    chk("clean_count_e10", press_count, 4'd1);
    chk("clean_led_e10", {3'b0, wait_led}, 4'd1);
    step(3);
    chk("clean_led_e13", {3'b0, wait_led}, 4'd1);
    step(1);
    chk("clean_led_e14", {3'b0, wait_led}, 4'd0);
    step(3);
    chk("clean_led_e17", {3'b0, wait_led}, 4'd0);
    step(1);
    chk("clean_led_e18", {3'b0, wait_led}, 4'd1);
    step(4);
    chk("clean_led_e22", {3'b0, wait_led}, 4'd0);
    step(7);
    btn_n = 1'b1;
    step(12);
    chk("release_level", {3'b0, btn_level}, 4'd0);
    chk("release_req_held", {3'b0, ped_req}, 4'd1);
    chk("release_count", press_count, 4'd1);
    req_ack = 1'b1;
    step(1);
    req_ack = 1'b0;
    chk("ack_req", {3'b0, ped_req}, 4'd0);
    chk("ack_led", {3'b0, wait_led}, 4'd0);
    light_state = 2'b10;
    btn_n = 1'b0;
    step(11);
    chk("red_level", {3'b0, btn_level}, 4'd1);
    chk("red_req", {3'b0, ped_req}, 4'd0);
    btn_n = 1'b1;
    step(12);
    chk("red_count", press_count, 4'd1);
    light_state = 2'b00;
    step(1);
    btn_n = 1'b0;
    step(11);
    chk("regreen_req", {3'b0, ped_req}, 4'd1);
    chk("regreen_count", press_count, 4'd2);
    btn_n = 1'b1;
    req_ack = 1'b1;
    step(1);
    req_ack = 1'b0;
    chk("ack2_req", {3'b0, ped_req}, 4'd0);
    step(12);
    for (int i = 0; i < 6; i++) begin
      btn_n = 1'b0;
      step(5);
      btn_n = 1'b1;
      step(3);
      chk("bounce_level_mid", {3'b0, btn_level}, 4'd0);
    end
    step(12);
    chk("bounce_level", {3'b0, btn_level}, 4'd0);
    chk("bounce_req", {3'b0, ped_req}, 4'd0);
    chk("bounce_count", press_count, 4'd2);
    light_state = 2'b01;
    btn_n = 1'b0;
    step(11);
    chk("yellow_req", {3'b0, ped_req}, 4'd0);
    btn_n = 1'b1;
    step(12);
    chk("yellow_count", press_count, 4'd2);
    light_state = 2'b00;
    step(1);
    btn_n = 1'b0;
    step(11);
    chk("expiry_req_before", {3'b0, ped_req}, 4'd1);
    chk("expiry_count", press_count, 4'd3);
    btn_n = 1'b1;
    light_state = 2'b01;
    step(1);
    chk("expiry_req_after", {3'b0, ped_req}, 4'd0);
    chk("expiry_led_after", {3'b0, wait_led}, 4'd0);
    step(12);
    light_state = 2'b00;
    step(1);
    btn_n = 1'b0;
    step(11);
    chk("both_req_before", {3'b0, ped_req}, 4'd1);
    chk("both_count", press_count, 4'd4);
    btn_n = 1'b1;
    req_ack = 1'b1;
    light_state = 2'b01;
    step(1);
    req_ack = 1'b0;
    chk("both_req_after", {3'b0, ped_req}, 4'd0);
    step(12);
    btn_n = 1'b0;
    step(10);
    chk("served_level", {3'b0, btn_level}, 4'd1);
    light_state = 2'b00;
    step(1);
    chk("served_press_lost", {3'b0, ped_req}, 4'd0);
    chk("served_count", press_count, 4'd4);
    btn_n = 1'b1;
    step(12);
    chk("served_idle_req", {3'b0, ped_req}, 4'd0);
    btn_n = 1'b0;
    step(11);
    chk("pre_reset_req", {3'b0, ped_req}, 4'd1);
    chk("pre_reset_count", press_count, 4'd5);
    btn_n = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk("midreq_rst_req", {3'b0, ped_req}, 4'd0);
    chk("midreq_rst_count", press_count, 4'd0);
    chk("midreq_rst_led", {3'b0, wait_led}, 4'd0);
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      btn_n = 1'b0;
      step(11);
      chk("sat_req", {3'b0, ped_req}, 4'd1);
      if (i == 0) chk("sat_count_first", press_count, 4'd1);
      if (i == 14) chk("sat_count_15", press_count, 4'd15);
      btn_n = 1'b1;
      req_ack = 1'b1;
      step(1);
      req_ack = 1'b0;
      step(12);
    end
    chk("sat_count_final", press_count, 4'd15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
